inst_fetch: RTL

//   Instruction fetch unit: the reader side of the synchronous instruction ROM (SYNC_ROM).

---
 rtl/inst_fetch_pkg.sv | 8 +
 rtl/inst_fetch.sv | 62 ++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// ISA-wide widths and reset PC shared by the instruction ROM, fetch and decode.
package inst_fetch_pkg;

  localparam int ISA_DWIDTH = 16;
  localparam int ISA_AWIDTH = 12;
  localparam logic [ISA_AWIDTH-1:0] ISA_RESET_PC = '0;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, requests the sync ROM, hands {pc, inst} to decode.
// One cycle request-to-valid; decode backpressure freezes the ROM so its output word holds.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                DWIDTH   = ISA_DWIDTH,
  parameter int                AWIDTH   = ISA_AWIDTH,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(ISA_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_dout,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst,
  output logic [AWIDTH-1:0] inst_pc,
  input  logic              jump_valid,
  input  logic [AWIDTH-1:0] jump_target
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] req_pc_q, req_pc_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              advance;

  always_comb begin
    advance    = !rsp_vld_q || inst_ready;
    rom_en     = !rst && (jump_valid || (run && advance));
    rom_addr   = jump_valid ? jump_target : pc_q;
    // A redirect squashes whatever word sits on the output this cycle.
    inst_valid = !rst && rsp_vld_q && !jump_valid;
    inst       = rom_dout;
    inst_pc    = req_pc_q;

    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    rsp_vld_d = rsp_vld_q;
    if (rom_en) begin
      req_pc_d  = rom_addr;
      pc_d      = rom_addr + AWIDTH'(1);
      rsp_vld_d = 1'b1;
    end else if (inst_valid && inst_ready) begin
      rsp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

endmodule
